// File: rtl/adc_sched_pkg.sv
// Shared constants and types for the ADC scan scheduler.
// Register map, control/status bit positions and FSM states.
package adc_sched_pkg;

   localparam int REG_AW = 3;

   localparam logic [REG_AW-1:0] REG_CTRL   = 3'd0;
   localparam logic [REG_AW-1:0] REG_PERIOD = 3'd1;
   localparam logic [REG_AW-1:0] REG_STATUS = 3'd2;
   localparam logic [REG_AW-1:0] REG_DATA   = 3'd3;
   localparam logic [REG_AW-1:0] REG_CLEAR  = 3'd4;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_SS  = 1;
   localparam int CTRL_IRQ = 2;

   localparam int ST_OVF  = 8;
   localparam int ST_OVR  = 9;
   localparam int ST_TMO  = 10;
   localparam int ST_BUSY = 11;

   localparam int CLR_FLUSH = 0;
   localparam int CLR_FLAGS = 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      STORE,
      NEXT
   } state_e;

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Avalon-MM register port of the ADC scan scheduler.
// readdata is registered in the slave: one cycle read latency.
interface adc_scan_scheduler_if;
   import adc_sched_pkg::*;

   logic [REG_AW-1:0] address;
   logic              write;
   logic [31:0]       writedata;
   logic              read;
   logic [31:0]       readdata;

   modport master (
      output address, write, writedata, read,
      input  readdata
   );

   modport slave (
      input  address, write, writedata, read,
      output readdata
   );

endinterface

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with flush; a pop frees space for a
// same-cycle push when full, and flush overrides both.
module adc_sample_fifo #(
   parameter int W  = 12,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  level_o
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign level_o = cnt_q;

endmodule

// File: rtl/adc_scan_scheduler.sv
// Scans the shared ADC across NUM_CH channels once per frame period
// and queues channel-tagged samples for the CPU over Avalon-MM.
module adc_scan_scheduler
   import adc_sched_pkg::*;
#(
   parameter int NUM_CH   = 6,
   parameter int DATA_W   = 8,
   parameter int PER_W    = 16,
   parameter int FIFO_AW  = 4,
   parameter int BUSY_TMO = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   adc_scan_scheduler_if.slave av,
   output logic [2:0]          adc_sel,
   output logic                adc_start,
   input  logic                adc_busy,
   input  logic [DATA_W-1:0]   adc_data,
   output logic                irq
);
   localparam int FW = 4 + DATA_W;
   localparam int LW = FIFO_AW + 1;
   localparam int TW = $clog2(BUSY_TMO + 1);

   state_e            state_q, state_d;
   logic [2:0]        ch_q, ch_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [PER_W-1:0]  per_q, per_d, cnt_q, cnt_d;
   logic              en_q, en_d, ss_q, ss_d, ie_q, ie_d;
   logic              ovf_q, ovf_d, ovr_q, ovr_d, tmo_q, tmo_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              tick, push, tmo_set, ss_done, busy;
   logic              wr_ctrl, wr_per, flush, clr_flags, pop;
   logic              full, empty;
   logic [LW-1:0]     level;
   logic [FW-1:0]     fifo_dout;
   logic              unused_wd;

   assign unused_wd = ^av.writedata;

   assign wr_ctrl   = av.write & (av.address == REG_CTRL);
   assign wr_per    = av.write & (av.address == REG_PERIOD);
   assign flush     = av.write & (av.address == REG_CLEAR)
                    & av.writedata[CLR_FLUSH];
   assign clr_flags = av.write & (av.address == REG_CLEAR)
                    & av.writedata[CLR_FLAGS];
   assign pop       = av.read & (av.address == REG_DATA);

   assign tick      = en_q & (cnt_q == '0);
   assign busy      = (state_q != IDLE);
   assign adc_start = (state_q == START);
   assign adc_sel   = ch_q;
   assign irq       = ie_q & ((level >= LW'(NUM_CH)) | ovf_q | tmo_q);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = data_q;
      tcnt_d  = tcnt_q;
      push    = 1'b0;
      tmo_set = 1'b0;
      ss_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            ch_d = '0;
            if (en_q) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!en_q) begin
               state_d = IDLE;
            end else if (tick) begin
               ch_d    = '0;
               state_d = START;
            end
         end
         START: begin
            tcnt_d  = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (adc_busy) begin
               state_d = WAIT_DONE;
            end else if (tcnt_q == TW'(BUSY_TMO - 1)) begin
               tmo_set = 1'b1;
               state_d = NEXT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!adc_busy) begin
               data_d  = adc_data;
               state_d = STORE;
            end
         end
         STORE: begin
            push    = 1'b1;
            state_d = NEXT;
         end
         NEXT: begin
            if (!en_q) begin
               state_d = IDLE;
            end else if (ch_q == 3'(NUM_CH - 1)) begin
               ss_done = ss_q;
               state_d = ss_q ? IDLE : WAIT_TICK;
            end else begin
               ch_d    = ch_q + 1'b1;
               state_d = START;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en_d  = en_q;
      ss_d  = ss_q;
      ie_d  = ie_q;
      per_d = per_q;
      if (wr_ctrl) begin
         en_d = av.writedata[CTRL_EN];
         ss_d = av.writedata[CTRL_SS];
         ie_d = av.writedata[CTRL_IRQ];
      end
      if (wr_per)  per_d = av.writedata[PER_W-1:0];
      if (ss_done) en_d = 1'b0;
      cnt_d = '0;
      if (en_q) cnt_d = tick ? per_q : cnt_q - 1'b1;
      // The first tick after enable lands in IDLE; it is not a lost frame.
      ovr_d = (ovr_q & ~clr_flags)
            | (tick & !(state_q inside {IDLE, WAIT_TICK}));
      ovf_d = (ovf_q & ~clr_flags) | (push & full & ~pop);
      tmo_d = (tmo_q & ~clr_flags) | tmo_set;
   end

   always_comb begin
      rdata_d = '0;
      unique case (av.address)
         REG_CTRL:   rdata_d = {29'b0, ie_q, ss_q, en_q};
         REG_PERIOD: rdata_d = 32'(per_q);
         REG_STATUS: begin
            rdata_d          = 32'(level);
            rdata_d[ST_OVF]  = ovf_q;
            rdata_d[ST_OVR]  = ovr_q;
            rdata_d[ST_TMO]  = tmo_q;
            rdata_d[ST_BUSY] = busy;
         end
         REG_DATA:   rdata_d = empty ? '0 : 32'(fifo_dout);
         default:    rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         data_q  <= '0;
         tcnt_q  <= '0;
         per_q   <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         ss_q    <= 1'b0;
         ie_q    <= 1'b0;
         ovf_q   <= 1'b0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         tcnt_q  <= tcnt_d;
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         ss_q    <= ss_d;
         ie_q    <= ie_d;
         ovf_q   <= ovf_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         rdata_q <= rdata_d;
      end
   end

   assign av.readdata = rdata_q;

   adc_sample_fifo #(
      .W  (FW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .din_i   ({4'(ch_q), data_q}),
      .pop_i   (pop),
      .flush_i (flush),
      .dout_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: reactive ADC model plus a queue-based
// model of the expected sample stream, flags and interrupt.
module tb_adc_scan_scheduler;
   import adc_sched_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] adc_sel;
   logic       adc_start;
   logic       adc_busy = 1'b0;
   logic [7:0] adc_data = 8'h00;
   logic       irq;

   adc_scan_scheduler_if av();

   adc_scan_scheduler dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .av        (av),
      .adc_sel   (adc_sel),
      .adc_start (adc_start),
      .adc_busy  (adc_busy),
      .adc_data  (adc_data),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;

   int rise_d = 3, len = 4, skip_ch = 8;
   bit data_rand = 0;
   bit active = 0;
   int acnt, pend_ch;
   int exp_ch, n_start, t0, cur_per;
   bit t0_valid, chk_gap;
   logic [31:0] mq[$];
   bit m_ovf = 0, m_tmo = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ADC front end: busy rises rise_d cycles after start, falls len
   // cycles later with the result; skip_ch never answers.
   task automatic adc_model();
      logic [7:0] d;
      if (!reset_n) begin
         active   = 0;
         adc_busy = 1'b0;
         return;
      end
      if (adc_start) begin
         check("sel_order", 32'(adc_sel), 32'(exp_ch));
         exp_ch = (exp_ch == 5) ? 0 : exp_ch + 1;
         n_start++;
         if (adc_sel == 3'd0) begin
            if (t0_valid && chk_gap)
               check("frame_gap", 32'(cyc - t0), 32'(cur_per + 1));
            t0       = cyc;
            t0_valid = 1;
         end
         pend_ch = int'(adc_sel);
         acnt    = 0;
         active  = (pend_ch != skip_ch);
         if (!active) m_tmo = 1;
      end else if (active) begin
         acnt++;
         if (acnt == rise_d) adc_busy = 1'b1;
         if (acnt == rise_d + len) begin
            d        = data_rand ? 8'($urandom) : 8'(8'h10 + pend_ch);
            adc_busy = 1'b0;
            adc_data = d;
            check("sel_hold", 32'(adc_sel), 32'(pend_ch));
            if (mq.size() == 16) m_ovf = 1;
            else mq.push_back({20'b0, 4'(pend_ch), d});
            active = 0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      adc_model();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      av.address   = a;
      av.writedata = d;
      av.write     = 1'b1;
      step();
      av.write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      av.address = a;
      av.read    = 1'b1;
      step();
      d          = av.readdata;
      av.read    = 1'b0;
   endtask

   function automatic logic [31:0] exp_status(input bit ovr);
      return 32'(mq.size()) | (32'(m_ovf) << 8) | (32'(ovr) << 9)
           | (32'(m_tmo) << 10);
   endfunction

   task automatic run(input int per, input bit ss, input bit ie,
                      input int target, input bit exp_ovr,
                      input bit drain);
      logic [31:0] d;
      int n, budget, cnt;
      cur_per  = per;
      chk_gap  = !exp_ovr;
      t0_valid = 0;
      exp_ch   = 0;
      n_start  = 0;
      budget   = (target / 6 + 3) * (per + 1) + 300;
      wr(REG_PERIOD, 32'(per));
      wr(REG_CTRL, {29'b0, ie, ss, 1'b1});
      n = 0;
      while (n_start < target && n < budget) begin
         step();
         n++;
      end
      check("starts", 32'(n_start), 32'(ss ? 6 : target));
      if (ss) begin
         rd(REG_CTRL, d);
         check("ss_ctrl", d, {29'b0, ie, 2'b10});
         rd(REG_STATUS, d);
         check("ss_busy", 32'(d[ST_BUSY]), 32'h0);
      end
      wr(REG_CTRL, {29'b0, ie, 2'b00});
      n = 0;
      do begin
         rd(REG_STATUS, d);
         n++;
      end while (d[ST_BUSY] && n < 100);
      check("idle_wait", 32'(d[ST_BUSY]), 32'h0);
      rd(REG_STATUS, d);
      check("status", d, exp_status(exp_ovr));
      check("irq", 32'(irq),
            32'(ie & ((mq.size() >= 6) | m_ovf | m_tmo)));
      if (drain) begin
         cnt = mq.size();
         for (int i = 0; i < cnt; i++) begin
            rd(REG_DATA, d);
            check("data", d, mq.pop_front());
         end
         rd(REG_DATA, d);
         check("data_empty", d, 32'h0);
      end
      wr(REG_CLEAR, 32'h3);
      mq.delete();
      m_ovf = 0;
      m_tmo = 0;
      rd(REG_STATUS, d);
      check("status_clr", d, 32'h0);
      check("irq_clr", 32'(irq), 32'h0);
   endtask

   initial begin
      logic [31:0] d;
      int n;
      av.address   = '0;
      av.write     = 1'b0;
      av.read      = 1'b0;
      av.writedata = '0;
      repeat (3) step();
      check("rst_start", 32'(adc_start), 32'h0);
      check("rst_rdata", av.readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      step();
      rd(REG_CTRL, d);   check("ctrl0", d, 32'h0);
      rd(REG_PERIOD, d); check("period0", d, 32'h0);
      rd(REG_STATUS, d); check("status0", d, 32'h0);
      rd(REG_DATA, d);   check("data0", d, 32'h0);
      rd(3'd6, d);       check("unused_addr", d, 32'h0);
      wr(REG_PERIOD, 32'hBEEF_1234);
      rd(REG_PERIOD, d); check("period_rw", d, 32'h1234);

      // two frames, fixed data pattern
      run(99, 0, 0, 12, 0, 1);
      // single shot
      run(99, 1, 0, 7, 0, 1);
      // channel 2 never answers
      skip_ch = 2;
      run(99, 0, 1, 6, 0, 1);
      skip_ch = 8;
      // three frames unread: overflow, then clear
      run(99, 0, 0, 18, 0, 0);
      // conversions slower than the frame period
      rise_d = 1;
      len    = 10;
      run(5, 0, 0, 12, 1, 1);

      data_rand = 1;
      for (int r = 0; r < 4; r++) begin
         rise_d  = $urandom_range(4, 1);
         len     = $urandom_range(6, 1);
         skip_ch = $urandom_range(7, 0);
         run($urandom_range(250, 150), 0, 1'($urandom_range(1, 0)),
             $urandom_range(20, 3), 0, 1);
      end
      data_rand = 0;
      skip_ch   = 8;

      // reset while waiting for conversion data
      rise_d   = 1;
      len      = 20;
      exp_ch   = 0;
      n_start  = 0;
      t0_valid = 0;
      chk_gap  = 0;
      wr(REG_PERIOD, 32'd20);
      wr(REG_CTRL, 32'h5);
      n = 0;
      while (!adc_busy && n < 200) begin
         step();
         n++;
      end
      check("busy_seen", 32'(adc_busy), 32'h1);
      step();
      step();
      reset_n = 1'b0;
      #1;
      check("mid_rst_start", 32'(adc_start), 32'h0);
      check("mid_rst_rdata", av.readdata, 32'h0);
      check("mid_rst_sel", 32'(adc_sel), 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      mq.delete();
      m_ovf  = 0;
      m_tmo  = 0;
      exp_ch = 0;
      step();
      reset_n = 1'b1;
      step();
      rd(REG_STATUS, d); check("post_rst_status", d, 32'h0);
      rd(REG_CTRL, d);   check("post_rst_ctrl", d, 32'h0);
      rd(REG_DATA, d);   check("post_rst_data", d, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences the shared 8-bit ADC across the analyzer's voltage/current channels (default 3 V + 3 I) at a programmable sample period.
- Each conversion result is tagged with its channel number and buffered in a small FIFO.
- Nios II reads results and status through an Avalon-MM slave with registered readdata (1-cycle read latency).
- Replaces per-channel PIO polling, so all channels are sampled from one deterministic timebase.

Parameters:
- NUM_CH, 6, channels scanned per frame (1..8)
- DATA_W, 8, ADC sample width
- PER_W, 16, sample-period counter width
- FIFO_AW, 4, FIFO address width (depth 16)
- BUSY_TMO, 15, max cycles to wait for adc_busy rise after start

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- address  in  3  Avalon register select
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  registered read data
- adc_sel  out  3  channel mux select to ADC front end
- adc_start  out  1  one-cycle conversion start pulse
- adc_busy  in  1  ADC converting (high from start until data valid)
- adc_data  in  DATA_W  conversion result, valid when busy falls
- irq  out  1  level interrupt

Behaviour:
- Reset is asynchronous on reset_n (active-low); clk is the clock. All outputs and registers reset to 0, FSM to IDLE, FIFO empty, PERIOD=0.
- Register map (word address):
  - 0 CTRL rw: b0 enable, b1 single_shot, b2 irq_en.
  - 1 PERIOD rw: frame period in clocks, minus 1.
  - 2 STATUS ro: b[4:0] fifo level, b8 overflow, b9 overrun, b10 timeout, b11 busy.
  - 3 DATA ro: {20'b0, ch[3:0], data[7:0]}; a read pops the FIFO. Reading an empty FIFO returns 0 and does not pop.
  - 4 CLEAR wo: b0 flush FIFO, b1 clear sticky flags.
  - Unused addresses read 0.
- readdata is updated every clk with the mux output, giving 1-cycle latency. A DATA pop occurs on the cycle read is high with address 3.
- Period counter:
  - Free-runs only while enable=1; loads PERIOD on reaching 0 and asserts a tick.
  - Clearing enable resets the counter and returns the FSM to IDLE after any in-flight conversion finishes its STORE.
- FSM:
  - IDLE: enable -> WAIT_TICK.
  - WAIT_TICK: tick -> START with ch=0.
  - START: adc_sel=ch, adc_start=1 for exactly one cycle -> WAIT_BUSY.
  - WAIT_BUSY: busy=1 -> WAIT_DONE. If BUSY_TMO cycles elapse first, set timeout, skip the channel -> NEXT.
  - WAIT_DONE: busy=0 -> capture adc_data -> STORE.
  - STORE: push {ch,data} -> NEXT.
  - NEXT: ch==NUM_CH-1 -> WAIT_TICK (single_shot: clear enable, -> IDLE); otherwise ch+1 -> START.
- adc_sel holds its value from START through STORE.
- Tick arriving while not in WAIT_TICK sets sticky overrun; that tick is dropped. The counter keeps running.
- FIFO full at STORE: sample dropped, sticky overflow set. Simultaneous push and pop when full: the pop happens first, then the push is accepted.
- Simultaneous flush and push: flush wins and the FIFO ends empty. Clearing sticky flags in the same cycle as a new event: the event wins.
- irq = irq_en & (level >= NUM_CH | overflow | timeout).
- PERIOD=0 means a tick every cycle; overrun flags accordingly.

Decomposition:
- Shared package adc_sched_pkg holds:
  - register address constants (REG_CTRL..REG_CLEAR);
  - STATUS/CTRL bit indices;
  - FSM state enum: IDLE, WAIT_TICK, START, WAIT_BUSY, WAIT_DONE, STORE, NEXT.
- One sub-module: adc_sample_fifo, a synchronous FIFO of width 4+DATA_W with push/pop/flush, full/empty and level outputs.

Test Plan:
- PERIOD=99, NUM_CH=6, enable; ADC model with busy 3 cycles after start and data=0x10+ch -> six DATA reads return 0x010..0x515 in order; adc_start pulses 100 clocks apart per frame.
- single_shot=1 -> exactly one frame of 6 samples, then CTRL.b0 reads 0 and STATUS.b11=0.
- Model never raises busy on ch 2 -> timeout set after 15 cycles; FIFO holds ch 0,1,3,4,5 only; irq when irq_en=1.
- No reads for 3 frames (18 samples) -> level=16, overflow=1; CLEAR=0x3 -> level 0, flags 0.
- PERIOD=5 with 10-cycle conversions -> overrun=1, frames still complete with ch order intact.
- Assert reset_n mid-WAIT_DONE -> adc_start=0, readdata=0, FIFO empty, FSM in IDLE immediately.
